// File: rtl/pwm_pkg.sv
// Shared types and constants for the SPI command sequencer in front of the PWM register bank.
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_CMD   = 3'd0,
    ST_WDATA = 3'd1,
    ST_RWAIT = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int CMD_RW_BIT  = 7;
  localparam int ADDR_W_DEF  = 6;
  localparam int RD_LAT_DEF  = 1;

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Byte-side (SPI bridge) and register-side (PWM bank) signals of the command sequencer.
interface spi_cmd_sequencer_if #(
  parameter int ADDR_W = 6
) ();

  logic              cs_n;
  logic              byte_sync;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr;
  logic [7:0]        reg_wdata;
  logic              reg_rd;
  logic [7:0]        reg_rdata;
  logic              busy;

  modport slave (
    input  cs_n, byte_sync, data_in, reg_rdata,
    output data_out, reg_addr, reg_wr, reg_wdata, reg_rd, busy
  );

  modport master (
    output cs_n, byte_sync, data_in, reg_rdata,
    input  data_out, reg_addr, reg_wr, reg_wdata, reg_rd, busy
  );

endinterface

// File: rtl/spi_cmd_sequencer.sv
// Decodes SPI frames (command byte + data bytes) into single-cycle register strobes.
// Define SPI_CMD_BURST_EN for address auto-increment bursts within one cs_n frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CMD   | waiting for the command byte of a frame
// ST_WDATA | write command latched, waiting for the data byte
// ST_RWAIT | read strobe issued, counting down RD_LATENCY to capture
// ST_RDATA | read data staged on data_out, waiting for the dummy byte
// ST_DONE  | frame complete, bytes ignored until cs_n rises
module spi_cmd_sequencer
  import pwm_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RD_LATENCY = RD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_cmd_sequencer_if.slave   bus
);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_reg_addr;
  logic [7:0]        r_data_out;
  logic [7:0]        r_wdata;
  logic              r_wr;
  logic              r_rd;
  logic              r_busy;
  logic [1:0]        r_lat_cnt;

  logic              w_latch_cmd;
  logic              w_issue_wr;
  logic              w_issue_rd;
  logic              w_capture;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_cmd_addr = bus.data_in[ADDR_W-1:0];
  assign w_rd_addr  = w_latch_cmd ? w_cmd_addr : r_addr;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.cs_n) begin
      r_state <= ST_CMD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch_cmd = 1'b0;
    w_issue_wr  = 1'b0;
    w_issue_rd  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_CMD: begin
        if (bus.byte_sync) begin
          w_latch_cmd = 1'b1;
          if (bus.data_in[CMD_RW_BIT]) begin
            w_state_nxt = ST_WDATA;
          end else begin
            w_issue_rd  = 1'b1;
            w_state_nxt = ST_RWAIT;
          end
        end
      end
      ST_WDATA: begin
        if (bus.byte_sync) begin
          w_issue_wr  = 1'b1;
`ifdef SPI_CMD_BURST_EN
          w_state_nxt = ST_WDATA;
`else
          w_state_nxt = ST_DONE;
`endif
        end
      end
      ST_RWAIT: begin
        // byte_sync here is ignored: the master is clocking faster than the bank can answer
        if (r_lat_cnt == 2'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (bus.byte_sync) begin
`ifdef SPI_CMD_BURST_EN
          w_issue_rd  = 1'b1;
          w_state_nxt = ST_RWAIT;
`else
          w_state_nxt = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_CMD;
      end
    endcase
  end

  // r_addr always holds the address of the next access, so bursts just keep incrementing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_reg_addr <= '0;
      r_data_out <= 8'h00;
      r_wdata    <= 8'h00;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_busy     <= 1'b0;
      r_lat_cnt  <= 2'd0;
    end else begin
      if (r_lat_cnt != 2'd0) begin
        r_lat_cnt <= r_lat_cnt - 2'd1;
      end
      if (bus.cs_n) begin
        // abort leaves the latency counter running; its capture is dropped with the state
        r_addr     <= '0;
        r_reg_addr <= '0;
        r_data_out <= 8'h00;
        r_wdata    <= 8'h00;
        r_wr       <= 1'b0;
        r_rd       <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        r_wr <= w_issue_wr;
        r_rd <= w_issue_rd;
        if (w_latch_cmd) begin
          r_busy <= 1'b1;
          r_addr <= w_cmd_addr;
        end
        if (w_issue_wr) begin
          r_reg_addr <= r_addr;
          r_wdata    <= bus.data_in;
          r_addr     <= r_addr + ADDR_W'(1);
        end
        if (w_issue_rd) begin
          r_reg_addr <= w_rd_addr;
          r_addr     <= w_rd_addr + ADDR_W'(1);
          r_lat_cnt  <= 2'(RD_LATENCY);
        end
        if (w_capture) begin
          r_data_out <= bus.reg_rdata;
        end
      end
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.reg_addr  = r_reg_addr;
  assign bus.reg_wr    = r_wr;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_rd    = r_rd;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: directed frames push expected strobes, a monitor checks them.
module tb_spi_cmd_sequencer;

  localparam int AW     = 6;
  localparam int RD_LAT = 1;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   pend;
  logic [7:0] pend_exp;
  exp_t q[$];
  logic [7:0] rd_pipe [3];

  spi_cmd_sequencer_if #(.ADDR_W(AW)) bus ();

  spi_cmd_sequencer #(.ADDR_W(AW), .RD_LATENCY(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
    return {2'b00, a} ^ 8'h50;
  endfunction

  // register bank model: data valid RD_LAT cycles after the strobe, garbage otherwise
  always @(posedge clk) begin
    rd_pipe[0] <= bus.reg_rd ? mem_val(bus.reg_addr) : 8'hEE;
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign bus.reg_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
    exp_t e;
    e.wr = wr; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.byte_sync = 1'b1;
    bus.data_in   = b;
    @(negedge clk);
    bus.byte_sync = 1'b0;
    bus.data_in   = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.cs_n = 1'b0;
  endtask

  task automatic end_frame();
    @(negedge clk);
    bus.cs_n = 1'b1;
    @(negedge clk);
    chk("end_busy", {31'd0, bus.busy}, 32'd0);
    chk("end_data_out", {24'd0, bus.data_out}, 32'd0);
    chk("end_reg_addr", {26'd0, bus.reg_addr}, 32'd0);
  endtask

  // monitor: pops an expectation for every strobe and checks the staged read byte
  initial begin
    exp_t e;
    pend = 0;
    pend_exp = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pend != 0) begin
          pend--;
          if (pend == 0) chk("rd_data_out", {24'd0, bus.data_out}, {24'd0, pend_exp});
        end
        if (bus.reg_wr || bus.reg_rd) begin
          chk("strobe_exclusive", {31'd0, bus.reg_wr & bus.reg_rd}, 32'd0);
          if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_strobe: wr=%0b rd=%0b addr=0x%0h required none at %0t",
                     bus.reg_wr, bus.reg_rd, bus.reg_addr, $time);
          end else begin
            e = q.pop_front();
            chk("strobe_kind_wr", {31'd0, bus.reg_wr}, {31'd0, e.wr});
            chk("strobe_addr", {26'd0, bus.reg_addr}, {26'd0, e.addr});
            if (e.wr) begin
              chk("strobe_wdata", {24'd0, bus.reg_wdata}, {24'd0, e.data});
            end else begin
              pend     = RD_LAT + 1;
              pend_exp = e.data;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.cs_n = 1'b1;
    bus.byte_sync = 1'b0;
    bus.data_in = 8'h00;
    idle(3);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    chk("rst_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
    chk("rst_reg_rd", {31'd0, bus.reg_rd}, 32'd0);
    chk("rst_reg_addr", {26'd0, bus.reg_addr}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // single write, extra byte after completion must be ignored
    start_frame();
    push(1'b1, 6'h05, 8'h3C);
    send_byte(8'h85);
    chk("wr_busy_after_cmd", {31'd0, bus.busy}, 32'd1);
    send_byte(8'h3C);
    idle(3);
    send_byte(8'hFF);
    idle(2);
    chk("wr_busy_in_done", {31'd0, bus.busy}, 32'd1);
    end_frame();
    chk("wr_wdata_cleared", {24'd0, bus.reg_wdata}, 32'd0);

    // single read at 0x0A, bank returns 0x5A
    start_frame();
    push(1'b0, 6'h0A, 8'h5A);
    send_byte(8'h0A);
    idle(3);
    send_byte(8'h00);
    idle(2);
    chk("rd_data_held", {24'd0, bus.data_out}, 32'h5A);
    end_frame();

    // abort after command byte, then a normal write frame
    start_frame();
    send_byte(8'h81);
    bus.cs_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
    start_frame();
    push(1'b1, 6'h02, 8'h11);
    send_byte(8'h82);
    send_byte(8'h11);
    idle(2);
    end_frame();

    // write at top address; burst wraps to 0
    start_frame();
    push(1'b1, 6'h3F, 8'h01);
`ifdef SPI_CMD_BURST_EN
    push(1'b1, 6'h00, 8'h02);
`endif
    send_byte(8'hBF);
    send_byte(8'h01);
    send_byte(8'h02);
    idle(2);
    end_frame();

    // read at top address; burst continues at 0
    start_frame();
    push(1'b0, 6'h3F, 8'h6F);
`ifdef SPI_CMD_BURST_EN
    push(1'b0, 6'h00, 8'h50);
`endif
    send_byte(8'h3F);
    idle(3);
    send_byte(8'h00);
    idle(4);
    send_byte(8'h00);
    idle(4);
    end_frame();

    // reset mid-frame in WDATA: the next byte is a fresh command (read addr 7)
    start_frame();
    send_byte(8'h84);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    push(1'b0, 6'h07, 8'h57);
    send_byte(8'h07);
    idle(4);
    end_frame();

    // byte_sync together with cs_n rising in WDATA: no write
    start_frame();
    send_byte(8'h83);
    bus.byte_sync = 1'b1;
    bus.data_in   = 8'h99;
    bus.cs_n      = 1'b1;
    @(negedge clk);
    bus.byte_sync = 1'b0;
    bus.data_in   = 8'h00;
    chk("collide_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
    chk("collide_busy", {31'd0, bus.busy}, 32'd0);
    idle(3);

    chk("queue_drained", q.size(), 32'd0);
    chk("read_check_done", pend, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
